// File: rtl/fp32_pkg.sv
// Shared FP32 constants for the adder back end: field widths, mant_sum bit
// positions, the packer state encoding and a small packing helper.
package fp32_pkg;

    localparam int EXP_W      = 8;
    localparam int FRAC_W     = 23;
    localparam int SIG_W      = 24;
    localparam int MANT_SUM_W = 50;
    localparam int BIAS       = 127;

    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
    localparam logic [31:0]      QNAN    = 32'h7FC0_0000;

    // mant_sum layout: carry, hidden, fraction, guard, sticky field
    localparam int CARRY_BIT  = 49;
    localparam int HIDDEN_BIT = 48;
    localparam int FRAC_MSB   = 47;
    localparam int FRAC_LSB   = 25;
    localparam int GUARD_BIT  = 24;
    localparam int STICKY_MSB = 23;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_NORM  = 2'd1,
        ST_ROUND = 2'd2,
        ST_OUT   = 2'd3
    } pk_state_e;

    function automatic logic [31:0] fp_inf(input logic sign);
        return {sign, EXP_MAX, 23'h000000};
    endfunction

endpackage

// File: rtl/fp_add_packer_if.sv
// Handshake and data bundle between the operand preparer and the packer,
// plus the packed-result side towards the consumer.
interface fp_add_packer_if;

    logic                              in_valid;
    logic                              in_ready;
    logic [fp32_pkg::MANT_SUM_W-1:0]   mant_sum;
    logic [fp32_pkg::EXP_W-1:0]        exp_max;
    logic                              res_sig;
    logic                              NaN_res;
    logic                              inf_res;
    logic                              out_valid;
    logic                              out_ready;
    logic [31:0]                       result;
    logic                              overflow;
    logic                              inexact;

    modport master (
        output in_valid, mant_sum, exp_max, res_sig, NaN_res, inf_res, out_ready,
        input  in_ready, out_valid, result, overflow, inexact
    );

    modport slave (
        input  in_valid, mant_sum, exp_max, res_sig, NaN_res, inf_res, out_ready,
        output in_ready, out_valid, result, overflow, inexact
    );

endinterface

// File: rtl/fp_add_packer_rne_rounder.sv
// Combinational round-to-nearest-even on a 24-bit significand; shared by the
// add, mul and div packers.
module rne_rounder
    import fp32_pkg::*;
(
    input  logic [SIG_W-1:0] sig_i,
    input  logic             guard_i,
    input  logic             sticky_i,
    output logic [SIG_W-1:0] sig_o,
    output logic             carry_o,
    output logic             inexact_o
);

    logic           inc_s;
    logic [SIG_W:0] sum_s;

    // Round up above half, or exactly half when the kept lsb is odd.
    always_comb begin
        inc_s     = guard_i & (sticky_i | sig_i[0]);
        sum_s     = {1'b0, sig_i} + {{SIG_W{1'b0}}, inc_s};
        sig_o     = sum_s[SIG_W-1:0];
        carry_o   = sum_s[SIG_W];
        inexact_o = guard_i | sticky_i;
    end

endmodule

// File: rtl/fp_add_packer.sv
// FP32 adder back end: iterative normalisation, RNE rounding and IEEE-754
// packing of the preparer's aligned magnitude sum. One result in flight.
module fp_add_packer #(
    parameter int          MANT_W = 50,
    parameter logic [31:0] QNAN   = 32'h7FC0_0000
) (
    input  logic           clk,
    input  logic           rst,
    fp_add_packer_if.slave bus
);
    import fp32_pkg::*;

    pk_state_e         state_q, state_d;
    logic [MANT_W-1:0] mant_q, mant_d;
    logic [9:0]        exp_q, exp_d;
    logic              sign_q, sign_d;
    logic [31:0]       result_q, result_d;
    logic              ovf_q, ovf_d;
    logic              inx_q, inx_d;

    logic [SIG_W-1:0]  rnd_sig_s;
    logic              rnd_carry_s;
    logic              rnd_inexact_s;
    logic              sticky_s;
    logic [9:0]        exp_rnd_s;
    logic              hidden_s;
    logic [FRAC_W-1:0] frac_s;
    logic [EXP_W-1:0]  exp_field_s;

    assign sticky_s = |mant_q[STICKY_MSB:0];

    rne_rounder u_rnd (
        .sig_i     (mant_q[HIDDEN_BIT:FRAC_LSB]),
        .guard_i   (mant_q[GUARD_BIT]),
        .sticky_i  (sticky_s),
        .sig_o     (rnd_sig_s),
        .carry_o   (rnd_carry_s),
        .inexact_o (rnd_inexact_s)
    );

    // A rounding carry means the significand became 1.0 at the next exponent.
    assign exp_rnd_s   = exp_q + {9'd0, rnd_carry_s};
    assign hidden_s    = rnd_carry_s | rnd_sig_s[SIG_W-1];
    assign frac_s      = rnd_carry_s ? 23'd0 : rnd_sig_s[FRAC_W-1:0];
    assign exp_field_s = ((exp_rnd_s == 10'd1) && !hidden_s) ? 8'h00 : exp_rnd_s[EXP_W-1:0];

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            mant_q   <= '0;
            exp_q    <= 10'd0;
            sign_q   <= 1'b0;
            result_q <= 32'd0;
            ovf_q    <= 1'b0;
            inx_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mant_q   <= mant_d;
            exp_q    <= exp_d;
            sign_q   <= sign_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            inx_q    <= inx_d;
        end
    end

    // Next-state and datapath update, one normalisation decision per cycle.
    always_comb begin
        state_d  = state_q;
        mant_d   = mant_q;
        exp_d    = exp_q;
        sign_d   = sign_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        inx_d    = inx_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    mant_d = bus.mant_sum;
                    exp_d  = {2'b00, bus.exp_max};
                    sign_d = bus.res_sig;
                    ovf_d  = 1'b0;
                    inx_d  = 1'b0;
                    if (bus.NaN_res) begin
                        result_d = QNAN;
                        state_d  = ST_OUT;
                    end else if (bus.inf_res) begin
                        result_d = fp_inf(bus.res_sig);
                        state_d  = ST_OUT;
                    end else if (bus.mant_sum == '0) begin
                        result_d = {bus.res_sig, 31'd0};
                        state_d  = ST_OUT;
                    end else begin
                        state_d  = ST_NORM;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_NORM: begin
                if (mant_q[CARRY_BIT]) begin
                    mant_d  = {1'b0, mant_q[MANT_W-1:2], mant_q[1] | mant_q[0]};
                    exp_d   = exp_q + 10'd1;
                    state_d = ST_ROUND;
                end else if (mant_q[HIDDEN_BIT]) begin
                    state_d = ST_ROUND;
                end else if (exp_q <= 10'd1) begin
                    // Already at the minimum exponent: leave as a denormal.
                    state_d = ST_ROUND;
                end else begin
                    mant_d  = {mant_q[MANT_W-2:0], 1'b0};
                    exp_d   = exp_q - 10'd1;
                    state_d = ST_NORM;
                end
            end
            ST_ROUND: begin
                inx_d = rnd_inexact_s;
                if (exp_rnd_s >= 10'd255) begin
                    result_d = fp_inf(sign_q);
                    ovf_d    = 1'b1;
                end else begin
                    result_d = {sign_q, exp_field_s, frac_s};
                    ovf_d    = 1'b0;
                end
                state_d = ST_OUT;
            end
            ST_OUT: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_OUT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_OUT);
    assign bus.result    = result_q;
    assign bus.overflow  = ovf_q;
    assign bus.inexact   = inx_q;

endmodule

// File: tb/tb_fp_add_packer.sv
// Scoreboard bench for fp_add_packer: expectations are queued when a vector is
// driven and compared, with latency, when the packer presents its result.
module tb_fp_add_packer;
    import fp32_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fp_add_packer_if bus_if ();

    fp_add_packer #(.MANT_W(50), .QNAN(32'h7FC0_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        logic        inx;
        int          lat;
    } exp_t;

    typedef struct {
        logic [49:0] mant;
        logic [7:0]  ex;
        logic        sg;
        logic        nan;
        logic        inf;
        logic [31:0] res;
        logic        ovf;
        logic        inx;
        int          lat;
    } vec_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Drive one vector from IDLE; returns just after the accept edge.
    task automatic send(input vec_t v);
        exp_t e;
        int   n;
        @(negedge clk);
        n = 0;
        while (bus_if.in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        bus_if.in_valid = 1'b1;
        bus_if.mant_sum = v.mant;
        bus_if.exp_max  = v.ex;
        bus_if.res_sig  = v.sg;
        bus_if.NaN_res  = v.nan;
        bus_if.inf_res  = v.inf;
        e.res = v.res;
        e.ovf = v.ovf;
        e.inx = v.inx;
        e.lat = v.lat;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        bus_if.in_valid = 1'b0;
    endtask

    // Count edges (accept edge = 1) until out_valid, bounded.
    task automatic wait_out(output int lat);
        lat = 1;
        while (bus_if.out_valid !== 1'b1 && lat < 400) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic handshake();
        bus_if.out_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (bus_if.in_ready !== 1'b1) begin n_err++; $display("FAIL reset in_ready: got %b want 1", bus_if.in_ready); end
        n_vec++; if (bus_if.out_valid !== 1'b0) begin n_err++; $display("FAIL reset out_valid: got %b want 0", bus_if.out_valid); end
        n_vec++; if (bus_if.result !== 32'h0) begin n_err++; $display("FAIL reset result: got %h want 00000000", bus_if.result); end
        n_vec++; if (bus_if.overflow !== 1'b0) begin n_err++; $display("FAIL reset overflow: got %b want 0", bus_if.overflow); end
        n_vec++; if (bus_if.inexact !== 1'b0) begin n_err++; $display("FAIL reset inexact: got %b want 0", bus_if.inexact); end
        rst = 1'b0;
    endtask

    task automatic test_normalise();
        vec_t tbl[4];
        exp_t e;
        int   lat;
        tbl[0] = '{50'd1 << 49, 8'd127, 1'b0, 1'b0, 1'b0, 32'h4000_0000, 1'b0, 1'b0, 3};
        tbl[1] = '{50'd1 << 47, 8'd127, 1'b0, 1'b0, 1'b0, 32'h3F00_0000, 1'b0, 1'b0, 4};
        tbl[2] = '{50'd1 << 25, 8'd127, 1'b0, 1'b0, 1'b0, 32'h3400_0000, 1'b0, 1'b0, 26};
        tbl[3] = '{(50'd1 << 49) | 50'd1, 8'd127, 1'b1, 1'b0, 1'b0, 32'hC000_0000, 1'b0, 1'b1, 3};
        for (int i = 0; i < 4; i++) begin
            send(tbl[i]);
            wait_out(lat);
            e = sb_q.pop_front();
            n_vec++;
            if (bus_if.result !== e.res || bus_if.overflow !== e.ovf || bus_if.inexact !== e.inx || lat != e.lat) begin
                n_err++;
                $display("FAIL norm[%0d]: got %h ovf=%b inx=%b lat=%0d want %h ovf=%b inx=%b lat=%0d",
                         i, bus_if.result, bus_if.overflow, bus_if.inexact, lat, e.res, e.ovf, e.inx, e.lat);
            end
            handshake();
        end
    endtask

    task automatic test_specials();
        vec_t tbl[4];
        exp_t e;
        int   lat;
        tbl[0] = '{50'd1 << 48, 8'd100, 1'b0, 1'b1, 1'b0, 32'h7FC0_0000, 1'b0, 1'b0, 1};
        tbl[1] = '{50'd1 << 48, 8'd100, 1'b1, 1'b0, 1'b1, 32'hFF80_0000, 1'b0, 1'b0, 1};
        tbl[2] = '{50'd0,       8'd90,  1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1};
        tbl[3] = '{50'd1 << 49, 8'd254, 1'b1, 1'b1, 1'b1, 32'h7FC0_0000, 1'b0, 1'b0, 1};
        for (int i = 0; i < 4; i++) begin
            send(tbl[i]);
            wait_out(lat);
            e = sb_q.pop_front();
            n_vec++;
            if (bus_if.result !== e.res || bus_if.overflow !== e.ovf || bus_if.inexact !== e.inx || lat != e.lat) begin
                n_err++;
                $display("FAIL special[%0d]: got %h ovf=%b inx=%b lat=%0d want %h ovf=%b inx=%b lat=%0d",
                         i, bus_if.result, bus_if.overflow, bus_if.inexact, lat, e.res, e.ovf, e.inx, e.lat);
            end
            handshake();
        end
    endtask

    task automatic test_rounding();
        vec_t        tbl[6];
        exp_t        e;
        int          lat;
        logic [49:0] ones;
        ones = {26'd0, 24'hFFFFFF} << 25;
        tbl[0] = '{50'd1 << 49, 8'd254, 1'b0, 1'b0, 1'b0, 32'h7F80_0000, 1'b1, 1'b0, 3};
        tbl[1] = '{(50'd1 << 48) | (50'd1 << 25) | (50'd1 << 24), 8'd127, 1'b0, 1'b0, 1'b0, 32'h3F80_0002, 1'b0, 1'b1, 3};
        tbl[2] = '{(50'd1 << 48) | (50'd1 << 24), 8'd127, 1'b0, 1'b0, 1'b0, 32'h3F80_0000, 1'b0, 1'b1, 3};
        tbl[3] = '{ones | (50'd1 << 24), 8'd127, 1'b0, 1'b0, 1'b0, 32'h4000_0000, 1'b0, 1'b1, 3};
        tbl[4] = '{ones | (50'd1 << 24), 8'd254, 1'b0, 1'b0, 1'b0, 32'h7F80_0000, 1'b1, 1'b1, 3};
        tbl[5] = '{(50'd1 << 48) | (50'd1 << 24) | 50'd1, 8'd127, 1'b0, 1'b0, 1'b0, 32'h3F80_0001, 1'b0, 1'b1, 3};
        for (int i = 0; i < 6; i++) begin
            send(tbl[i]);
            wait_out(lat);
            e = sb_q.pop_front();
            n_vec++;
            if (bus_if.result !== e.res || bus_if.overflow !== e.ovf || bus_if.inexact !== e.inx || lat != e.lat) begin
                n_err++;
                $display("FAIL round[%0d]: got %h ovf=%b inx=%b lat=%0d want %h ovf=%b inx=%b lat=%0d",
                         i, bus_if.result, bus_if.overflow, bus_if.inexact, lat, e.res, e.ovf, e.inx, e.lat);
            end
            handshake();
        end
    endtask

    task automatic test_denormal();
        vec_t tbl[3];
        exp_t e;
        int   lat;
        tbl[0] = '{50'd1 << 25, 8'd1, 1'b0, 1'b0, 1'b0, 32'h0000_0001, 1'b0, 1'b0, 3};
        tbl[1] = '{({26'd0, 24'h7FFFFF} << 25) | (50'd1 << 24), 8'd1, 1'b0, 1'b0, 1'b0, 32'h0080_0000, 1'b0, 1'b1, 3};
        tbl[2] = '{50'd1 << 46, 8'd2, 1'b0, 1'b0, 1'b0, 32'h0040_0000, 1'b0, 1'b0, 4};
        for (int i = 0; i < 3; i++) begin
            send(tbl[i]);
            wait_out(lat);
            e = sb_q.pop_front();
            n_vec++;
            if (bus_if.result !== e.res || bus_if.overflow !== e.ovf || bus_if.inexact !== e.inx || lat != e.lat) begin
                n_err++;
                $display("FAIL denorm[%0d]: got %h ovf=%b inx=%b lat=%0d want %h ovf=%b inx=%b lat=%0d",
                         i, bus_if.result, bus_if.overflow, bus_if.inexact, lat, e.res, e.ovf, e.inx, e.lat);
            end
            handshake();
        end
    endtask

    task automatic test_backpressure();
        vec_t v;
        exp_t e;
        int   lat;
        v = '{(50'd1 << 48) | (50'd1 << 25) | (50'd1 << 24), 8'd127, 1'b1, 1'b0, 1'b0, 32'hBF80_0002, 1'b0, 1'b1, 3};
        bus_if.out_ready = 1'b0;
        send(v);
        wait_out(lat);
        e = sb_q.pop_front();
        n_vec++;
        if (bus_if.result !== e.res || bus_if.inexact !== e.inx || lat != e.lat) begin
            n_err++;
            $display("FAIL bp first: got %h inx=%b lat=%0d want %h inx=%b lat=%0d",
                     bus_if.result, bus_if.inexact, lat, e.res, e.inx, e.lat);
        end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            n_vec++;
            if (bus_if.out_valid !== 1'b1 || bus_if.in_ready !== 1'b0 || bus_if.result !== e.res || bus_if.inexact !== e.inx) begin
                n_err++;
                $display("FAIL bp hold[%0d]: got valid=%b ready=%b %h inx=%b want valid=1 ready=0 %h inx=%b",
                         c, bus_if.out_valid, bus_if.in_ready, bus_if.result, bus_if.inexact, e.res, e.inx);
            end
        end
        handshake();
        n_vec++;
        if (bus_if.out_valid !== 1'b0 || bus_if.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp release: got valid=%b ready=%b want valid=0 ready=1", bus_if.out_valid, bus_if.in_ready);
        end
    endtask

    task automatic test_reset_mid();
        vec_t v;
        exp_t e;
        int   lat;
        v = '{50'd1 << 25, 8'd127, 1'b0, 1'b0, 1'b0, 32'h3400_0000, 1'b0, 1'b0, 26};
        send(v);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        n_vec++;
        if (bus_if.out_valid !== 1'b0 || bus_if.in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL mid busy: got valid=%b ready=%b want valid=0 ready=0", bus_if.out_valid, bus_if.in_ready);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        void'(sb_q.pop_front());
        n_vec++;
        if (bus_if.out_valid !== 1'b0 || bus_if.in_ready !== 1'b1 || bus_if.result !== 32'h0) begin
            n_err++;
            $display("FAIL mid reset: got valid=%b ready=%b %h want valid=0 ready=1 00000000",
                     bus_if.out_valid, bus_if.in_ready, bus_if.result);
        end
        v = '{50'd1 << 47, 8'd127, 1'b0, 1'b0, 1'b0, 32'h3F00_0000, 1'b0, 1'b0, 4};
        send(v);
        wait_out(lat);
        e = sb_q.pop_front();
        n_vec++;
        if (bus_if.result !== e.res || bus_if.inexact !== e.inx || lat != e.lat) begin
            n_err++;
            $display("FAIL mid after: got %h inx=%b lat=%0d want %h inx=%b lat=%0d",
                     bus_if.result, bus_if.inexact, lat, e.res, e.inx, e.lat);
        end
        handshake();
    endtask

    // Second vector held valid behind the first: accepted latency+1 edges later.
    task automatic test_back_to_back();
        vec_t a;
        vec_t b;
        exp_t e;
        int   t;
        int   got;
        logic rdy;
        a = '{50'd1 << 49, 8'd127, 1'b0, 1'b0, 1'b0, 32'h4000_0000, 1'b0, 1'b0, 3};
        b = '{(50'd1 << 48) | (50'd1 << 24), 8'd127, 1'b1, 1'b0, 1'b0, 32'hBF80_0000, 1'b0, 1'b1, 7};
        bus_if.out_ready = 1'b1;
        send(a);
        bus_if.in_valid = 1'b1;
        bus_if.mant_sum = b.mant;
        bus_if.exp_max  = b.ex;
        bus_if.res_sig  = b.sg;
        bus_if.NaN_res  = b.nan;
        bus_if.inf_res  = b.inf;
        e.res = b.res; e.ovf = b.ovf; e.inx = b.inx; e.lat = b.lat;
        sb_q.push_back(e);
        t   = 1;
        got = 0;
        while (got < 2 && t < 60) begin
            if (bus_if.out_valid === 1'b1) begin
                e = sb_q.pop_front();
                n_vec++;
                got++;
                if (bus_if.result !== e.res || bus_if.inexact !== e.inx || t != e.lat) begin
                    n_err++;
                    $display("FAIL b2b[%0d]: got %h inx=%b at %0d want %h inx=%b at %0d",
                             got, bus_if.result, bus_if.inexact, t, e.res, e.inx, e.lat);
                end
            end
            rdy = bus_if.in_ready;
            @(posedge clk);
            #1;
            t++;
            if (rdy === 1'b1 && bus_if.in_valid === 1'b1) bus_if.in_valid = 1'b0;
        end
        if (got < 2) begin
            n_vec++;
            n_err++;
            $display("FAIL b2b timeout: got %0d results want 2", got);
            sb_q.delete();
        end
        bus_if.in_valid = 1'b0;
    endtask

    initial begin
        bus_if.in_valid  = 1'b0;
        bus_if.mant_sum  = 50'd0;
        bus_if.exp_max   = 8'd0;
        bus_if.res_sig   = 1'b0;
        bus_if.NaN_res   = 1'b0;
        bus_if.inf_res   = 1'b0;
        bus_if.out_ready = 1'b1;
        rst = 1'b1;
        test_reset();
        test_normalise();
        test_specials();
        test_rounding();
        test_denormal();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fp_add_packer.md
Name: fp_add_packer

Overview:
- Back end of the FP32 adder: the counterpart of the operand preparer.
- Accepts the aligned magnitude sum produced from the preparer's mantissas, plus the preparer's exp_max, result sign and NaN/inf flags.
- Normalises iteratively, rounds to nearest-even and packs an IEEE-754 single.
- Valid/ready on both sides; one result in flight.

Parameters:
- MANT_W, 50, width of mant_sum; fixed layout below, not meant to be overridden.
- QNAN, 32'h7FC0_0000, canonical NaN pattern emitted for any NaN result.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input transaction present
- in_ready  out  1  block can accept (high only in IDLE)
- mant_sum  in  50  non-negative magnitude; bit49 carry, bit48 hidden, 47:25 fraction, bit24 guard, 23:0 sticky field
- exp_max  in  8  biased exponent of bit48; preparer supplies 1 (not 0) when both operands are denormal
- res_sig  in  1  result sign from preparer
- NaN_res  in  1  result is NaN
- inf_res  in  1  result is infinity (sign in res_sig)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts
- result  out  32  packed FP32
- overflow  out  1  finite operands rounded/normalised to infinity
- inexact  out  1  guard or sticky nonzero at rounding

Behaviour:
- Reset: state=IDLE, in_ready=1, out_valid=0, result=0, overflow=0, inexact=0. Reset mid-operation discards the transaction.
- States: IDLE, NORM, ROUND, OUT.
- IDLE: accept on in_valid & in_ready; latch all inputs. Priority on accept:
  - NaN_res -> result=QNAN, go OUT.
  - else inf_res -> {res_sig, 8'hFF, 23'h0}, go OUT.
  - else mant_sum==0 -> {res_sig, 31'h0}, go OUT.
  - else go NORM.
  - Overflow and inexact cleared on each accept.
- NORM, one decision per cycle:
  - mant[49]=1 -> shift right 1, OR the shifted-out bit into bit0 (sticky), exp+1, go ROUND.
  - else mant[48]=1 -> go ROUND.
  - else exp==1 -> denormal result, go ROUND unshifted.
  - else shift left 1, exp-1, stay in NORM.
  - At most 48 left-shift cycles.
- ROUND:
  - lsb=bit25, g=bit24, s=|bits23:0.
  - Increment m[48:25] if g&(s|lsb).
  - Carry out of bit48 -> fraction=0, exp+1.
  - exp>=255 after normalise or round -> {sign, FF, 0}, overflow=1.
  - Exponent field is 0 iff exp==1 and the post-round hidden bit is 0. A denormal rounding up to hidden=1 gets field 1.
  - inexact=g|s. Go OUT.
- OUT: out_valid=1; result, overflow and inexact stable until the out_ready handshake; then go IDLE. No accept while in OUT (no bypass).
- Latency from the accept edge to out_valid high:
  - specials/zero: 1 cycle
  - already normalised or carry: 3 cycles
  - +k cycles for k left shifts
- Throughput: 1 result per (latency+1) cycles when out_ready is held high.

Decomposition:
- Shared package fp32_pkg: field widths (EXP_W=8, FRAC_W=23), EXP_MAX=8'hFF, BIAS=127, QNAN, the mant_sum bit-position constants, state enum.
- One natural sub-module: rne_rounder (combinational: 24-bit significand plus g/s in; rounded significand, carry and inexact out), reused later by mul/div packers.

Test Plan:
- 1.0+1.0: mant_sum=1<<49, exp_max=127, sign 0 -> 0x40000000, inexact=0, out_valid 3 cycles after accept.
- 1.5-1.0: mant_sum=1<<47, exp_max=127 -> 0x3F000000 after one left shift, out_valid 4 cycles after accept.
- NaN_res=1 with arbitrary mant -> 0x7FC00000 next cycle; inf_res=1, res_sig=1 -> 0xFF800000; zero sum with res_sig=0 -> 0x00000000.
- Overflow and RNE:
  - exp_max=254, mant_sum=1<<49 -> 0x7F800000, overflow=1.
  - Tie case: hidden=1, frac=1, g=1, s=0 with exp 127 -> 0x3F800002, inexact=1.
  - Tie case: frac=0, g=1, s=0 -> 0x3F800000, inexact=1.
- Denormal: exp_max=1, mant_sum=1<<25 -> 0x00000001, no shifts. Also exp_max=1, mant_sum=(24'hFFFFFF>>1)<<25 | 1<<24 (hidden 0, frac all ones, g=1, s=0) -> rounds to 0x00800000.
- Backpressure and reset: hold out_ready=0 for 5 cycles -> result stable, in_ready=0; assert rst while in NORM -> next cycle IDLE, out_valid=0, the next transaction is correct.
